// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: lowest-ID-first CAN transmit mailbox scheduler with arbitration retry and request timeout.
// Define CAN_TX_ABORT_EN to add the per-mailbox i_mb_abort input.
module can_tx_scheduler #(
    parameter int NUM_MB      = 4,
    parameter int RETRY_LIMIT = 8,
    parameter int REQ_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_MB-1:0] i_mb_load,
    input  logic [10:0]       i_mb_id_in,
    input  logic [63:0]       i_mb_data_in,
`ifdef CAN_TX_ABORT_EN
    input  logic [NUM_MB-1:0] i_mb_abort,
`endif
    output logic [NUM_MB-1:0] o_mb_pending,
    output logic              o_load_err,
    output logic [NUM_MB-1:0] o_tx_done,
    output logic [NUM_MB-1:0] o_tx_fail,
    output logic [10:0]       o_address,
    output logic [63:0]       o_data,
    output logic              o_send_data,
    input  logic              i_txing,
    input  logic              i_tx_complete,
    output logic              o_busy
);
    localparam int IW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    typedef enum logic [2:0] {IDLE, SELECT, REQUEST, ACTIVE, SETTLE} state_t;
    state_t            r_state, w_next;
    logic [10:0]       r_id  [NUM_MB];
    logic [63:0]       r_dat [NUM_MB];
    logic [7:0]        r_retry [NUM_MB];
    logic [NUM_MB-1:0] r_valid, w_abort_clr;
    logic [IW-1:0]     r_cur, w_sel, w_fly, w_load_idx;
    logic [15:0]       r_tmr;
    logic [7:0]        w_retry_inc;
    logic              r_abort, w_any, w_load_any, w_load_hit, w_load_ok, w_abort_fly;
    logic              w_timeout, w_lost, w_done, w_drop;
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < NUM_MB; i++)
            if (r_valid[i] && (!w_any || r_id[i] < r_id[w_sel])) begin
                w_sel = IW'(i);
                w_any = 1'b1;
            end
    end
    // Scan downward so the lowest set load bit is the one that sticks.
    always_comb begin
        w_load_idx = '0;
        w_load_any = 1'b0;
        for (int i = NUM_MB - 1; i >= 0; i--)
            if (i_mb_load[i]) begin
                w_load_idx = IW'(i);
                w_load_any = 1'b1;
            end
    end
    assign w_fly       = (r_state == SELECT) ? w_sel : r_cur;
    assign w_load_hit  = w_load_any && (r_state != IDLE) && (w_load_idx == w_fly);
    assign w_load_ok   = w_load_any && !w_load_hit;
    assign w_timeout   = (r_state == REQUEST) && !i_txing && (r_tmr == 16'(REQ_TIMEOUT - 1));
    assign w_done      = (r_state == ACTIVE) && i_tx_complete;
    assign w_lost      = (r_state == ACTIVE) && !i_tx_complete && !i_txing;
    assign w_retry_inc = r_retry[r_cur] + 8'd1;
`ifdef CAN_TX_ABORT_EN
    logic [NUM_MB-1:0] w_fly_oh;
    assign w_fly_oh    = (r_state != IDLE) ? (NUM_MB'(1) << w_fly) : '0;
    assign w_abort_fly = (r_state != IDLE) && i_mb_abort[w_fly];
    assign w_abort_clr = i_mb_abort & ~w_fly_oh;
`else
    assign w_abort_fly = 1'b0;
    assign w_abort_clr = '0;
`endif
    assign w_drop = w_timeout || (w_lost && w_retry_inc == 8'(RETRY_LIMIT)) ||
                    ((r_state == SETTLE) && (r_abort || w_abort_fly) && r_valid[r_cur]);
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? SELECT : IDLE;
            SELECT:  w_next = w_any ? REQUEST : IDLE;
            REQUEST: w_next = i_txing ? ACTIVE : (w_timeout ? SETTLE : REQUEST);
            ACTIVE:  w_next = (w_done || w_lost) ? SETTLE : ACTIVE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        o_send_data  = (r_state == REQUEST);
        o_busy       = (r_state != IDLE);
        o_mb_pending = r_valid;
    end
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_id[w_load_idx]  <= i_mb_id_in;
            r_dat[w_load_idx] <= i_mb_data_in;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_cur      <= '0;
            r_tmr      <= '0;
            r_abort    <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
            o_tx_done  <= '0;
            o_tx_fail  <= '0;
            o_load_err <= 1'b0;
            for (int i = 0; i < NUM_MB; i++)
                r_retry[i] <= '0;
        end else begin
            o_tx_done  <= '0;
            o_tx_fail  <= '0;
            o_load_err <= w_load_hit;
            r_tmr      <= (r_state == REQUEST) ? r_tmr + 16'd1 : '0;
            r_abort    <= (r_state == IDLE || r_state == SETTLE) ? 1'b0 : (r_abort || w_abort_fly);
            if (w_load_ok) begin
                r_valid[w_load_idx] <= 1'b1;
                r_retry[w_load_idx] <= '0;
            end
            if (r_state == SELECT) begin
                r_cur     <= w_sel;
                o_address <= r_id[w_sel];
                o_data    <= r_dat[w_sel];
            end
            if (w_done)
                o_tx_done[r_cur] <= 1'b1;
            if (w_drop)
                o_tx_fail[r_cur] <= 1'b1;
            if (w_done || w_drop) begin
                r_valid[r_cur] <= 1'b0;
                r_retry[r_cur] <= '0;
            end else if (w_lost)
                r_retry[r_cur] <= w_retry_inc;
            for (int i = 0; i < NUM_MB; i++)
                if (w_abort_clr[i])
                    r_valid[i] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: directed bench for can_tx_scheduler (NUM_MB=4, RETRY_LIMIT=3, REQ_TIMEOUT=16).
// Exercises the abort input as well when CAN_TX_ABORT_EN is defined.
module tb_can_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  mb_load = '0;
    logic [10:0] mb_id_in = '0;
    logic [63:0] mb_data_in = '0;
    logic [3:0]  mb_abort = '0;
    logic        txing = 1'b0;
    logic        tx_complete = 1'b0;
    logic [3:0]  o_mb_pending, o_tx_done, o_tx_fail;
    logic        o_load_err, o_send_data, o_busy;
    logic [10:0] o_address;
    logic [63:0] o_data;
    int          checks = 0;
    int          errors = 0;
    can_tx_scheduler #(.NUM_MB(4), .RETRY_LIMIT(3), .REQ_TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .i_mb_load(mb_load),
        .i_mb_id_in(mb_id_in),
        .i_mb_data_in(mb_data_in),
`ifdef CAN_TX_ABORT_EN
        .i_mb_abort(mb_abort),
`endif
        .o_mb_pending(o_mb_pending),
        .o_load_err(o_load_err),
        .o_tx_done(o_tx_done),
        .o_tx_fail(o_tx_fail),
        .o_address(o_address),
        .o_data(o_data),
        .o_send_data(o_send_data),
        .i_txing(txing),
        .i_tx_complete(tx_complete),
        .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic load(input logic [3:0] m, input logic [10:0] id, input logic [63:0] d);
        mb_load = m;
        mb_id_in = id;
        mb_data_in = d;
        step();
        mb_load = '0;
    endtask
    task automatic wait_send(input string tag);
        int n = 0;
        while (!o_send_data && n < 20) begin
            step();
            n++;
        end
        chk(tag, o_send_data, 1);
    endtask
    // Engine model: raise txing, then finish with tx_complete (ok) or drop txing (lost arbitration).
    task automatic engine(input bit ok, input logic [3:0] done_e, input logic [3:0] fail_e, input string tag);
        txing = 1'b1;
        step();
        chk({tag, "_send_low"}, o_send_data, 0);
        step();
        if (ok) tx_complete = 1'b1;
        else txing = 1'b0;
        step();
        chk({tag, "_done"}, o_tx_done, done_e);
        chk({tag, "_fail"}, o_tx_fail, fail_e);
        tx_complete = 1'b0;
        txing = 1'b0;
        step();
    endtask
    initial begin
        step();
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_send", o_send_data, 0);
        chk("rst_pending", o_mb_pending, 0);
        chk("rst_addr", o_address, 0);
        chk("rst_data", o_data, 0);
        chk("rst_pulses", {o_tx_done, o_tx_fail, o_load_err}, 0);
        rst = 1'b0;
        // Single frame, 3-cycle load-to-request latency
        load(4'b0001, 11'h123, 64'h1111_2222_3333_4444);
        chk("t1_pend", o_mb_pending, 4'b0001);
        chk("t1_send0", o_send_data, 0);
        step();
        chk("t1_busy", o_busy, 1);
        chk("t1_send1", o_send_data, 0);
        step();
        chk("t1_send", o_send_data, 1);
        chk("t1_addr", o_address, 11'h123);
        chk("t1_data", o_data, 64'h1111_2222_3333_4444);
        engine(1'b1, 4'b0001, 4'b0000, "t1");
        chk("t1_pend_clr", o_mb_pending, 0);
        chk("t1_idle", o_busy, 0);
        // Lower ID in MB2 goes before MB0
        load(4'b0001, 11'h200, 64'hAAAA);
        load(4'b0100, 11'h050, 64'hBBBB);
        chk("t2_pend", o_mb_pending, 4'b0101);
        wait_send("t2_wait_a");
        chk("t2_addr_a", o_address, 11'h050);
        chk("t2_data_a", o_data, 64'hBBBB);
        engine(1'b1, 4'b0100, 4'b0000, "t2a");
        wait_send("t2_wait_b");
        chk("t2_addr_b", o_address, 11'h200);
        engine(1'b1, 4'b0001, 4'b0000, "t2b");
        chk("t2_pend_clr", o_mb_pending, 0);
        // Multi-bit load writes MB1 only; three lost arbitrations then drop
        load(4'b1010, 11'h300, 64'hCCCC);
        chk("t3_pend", o_mb_pending, 4'b0010);
        wait_send("t3_wait1");
        chk("t3_addr", o_address, 11'h300);
        engine(1'b0, 4'b0000, 4'b0000, "t3r1");
        chk("t3_pend1", o_mb_pending, 4'b0010);
        wait_send("t3_wait2");
        engine(1'b0, 4'b0000, 4'b0000, "t3r2");
        wait_send("t3_wait3");
        engine(1'b0, 4'b0000, 4'b0010, "t3r3");
        chk("t3_pend_clr", o_mb_pending, 0);
        step();
        chk("t3_no_resend", {o_send_data, o_busy}, 0);
        // Request timeout 16 clk after send_data rises
        load(4'b1000, 11'h010, 64'hDDDD);
        wait_send("t4_wait");
        for (int i = 0; i < 15; i++) step();
        chk("t4_fail_early", o_tx_fail, 0);
        chk("t4_send_hold", o_send_data, 1);
        step();
        chk("t4_fail", o_tx_fail, 4'b1000);
        chk("t4_send_off", o_send_data, 0);
        chk("t4_pend_clr", o_mb_pending, 0);
        step();
        step();
        // Load into the in-flight mailbox is rejected
        load(4'b0001, 11'h123, 64'h5555);
        wait_send("t5_wait");
        txing = 1'b1;
        step();
        mb_load = 4'b0001;
        mb_id_in = 11'h7FF;
        mb_data_in = 64'h9999;
        step();
        mb_load = '0;
        chk("t5_load_err", o_load_err, 1);
        chk("t5_addr", o_address, 11'h123);
        chk("t5_data", o_data, 64'h5555);
        step();
        chk("t5_load_err_clr", o_load_err, 0);
        tx_complete = 1'b1;
        step();
        chk("t5_done", o_tx_done, 4'b0001);
        chk("t5_pend", o_mb_pending, 0);
        chk("t5_data_keep", o_data, 64'h5555);
        tx_complete = 1'b0;
        txing = 1'b0;
        step();
        // Reset mid-frame
        load(4'b0100, 11'h222, 64'h6666);
        wait_send("t6_wait");
        txing = 1'b1;
        step();
        load(4'b0010, 11'h0AA, 64'h7777);
        chk("t6_pend", o_mb_pending, 4'b0110);
        rst = 1'b1;
        step();
        chk("t6_send", o_send_data, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_pend_clr", o_mb_pending, 0);
        chk("t6_pulses", {o_tx_done, o_tx_fail}, 0);
        rst = 1'b0;
        txing = 1'b0;
        step();
        chk("t6_stay_idle", o_busy, 0);
`ifdef CAN_TX_ABORT_EN
        load(4'b0001, 11'h001, 64'h8888);
        wait_send("ab_wait");
        load(4'b1000, 11'h333, 64'h3333);
        chk("ab_pend", o_mb_pending, 4'b1001);
        mb_abort = 4'b1000;
        step();
        mb_abort = '0;
        chk("ab_pend_clr", o_mb_pending, 4'b0001);
        chk("ab_no_pulse", {o_tx_done, o_tx_fail}, 0);
        txing = 1'b1;
        step();
        mb_abort = 4'b0001;
        step();
        mb_abort = '0;
        txing = 1'b0;
        step();
        chk("ab_lost_nofail", o_tx_fail, 0);
        step();
        chk("ab_fly_fail", o_tx_fail, 4'b0001);
        chk("ab_fly_pend", o_mb_pending, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
